// File: rtl/lif_spike_decoder.sv
// lif_spike_decoder
//
// Turns a neuron spike train back into numbers. Two independent measurements
// are made from the rising edges of `spike`:
//   - rate: spikes counted over a fixed window of WINDOW enabled cycles,
//     saturating, with a sticky overflow flag for the window.
//   - isi : clock cycles between the two most recent rising edges,
//     saturating.
//
// Interface model: every output is a register. The *_valid outputs are
// single-cycle pulses that mark a fresh value in the matching data register.
// There is no ready/back-pressure; a consumer that needs every sample must
// capture it in the pulse cycle. The data registers hold between pulses.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (priority over en/edge)
//   en         in   measurement enable; low freezes counters and pulses
//   spike      in   spike level; each 0->1 transition is one spike
//   rate       out  [RATE_W] spikes in the last completed window (saturating)
//   rate_valid out  one-cycle pulse when rate/rate_ovf update
//   rate_ovf   out  last completed window saturated
//   isi        out  [ISI_W] cycles between the last two spikes (saturating)
//   isi_valid  out  one-cycle pulse when isi updates

module lif_spike_decoder #(
  parameter int unsigned WINDOW = 1000,
  parameter int unsigned RATE_W = 8,
  parameter int unsigned ISI_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              spike,
  output logic [RATE_W-1:0] rate,
  output logic              rate_valid,
  output logic              rate_ovf,
  output logic [ISI_W-1:0]  isi,
  output logic              isi_valid
);

  localparam int unsigned       WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [RATE_W-1:0] RATE_MAX = '1;
  localparam logic [ISI_W-1:0]  ISI_MAX  = '1;

  // IDLE: no spike seen since reset, so there is no interval to measure yet.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } isi_state_e;

  isi_state_e        state_q, state_d;
  logic              spike_q, spike_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [RATE_W-1:0] acc_q, acc_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [ISI_W-1:0]  tmr_q, tmr_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              rate_valid_q, rate_valid_d;
  logic              rate_ovf_q, rate_ovf_d;
  logic [ISI_W-1:0]  isi_q, isi_d;
  logic              isi_valid_q, isi_valid_d;

  logic              spike_edge;
  logic              win_last;
  logic [RATE_W-1:0] acc_sum;
  logic              ovf_now;
  logic [ISI_W-1:0]  tmr_inc;

  always_comb begin
    // spike_q tracks spike even while disabled, so a level that rose during
    // en=0 is not mistaken for a fresh edge once en returns.
    spike_edge = spike & ~spike_q & en;
    win_last   = (win_q == WIN_LAST);

    // Accumulator value including this cycle's edge, saturating.
    acc_sum = (spike_edge && (acc_q != RATE_MAX)) ? acc_q + 1'b1 : acc_q;
    // Sticky overflow: set when the count reaches the ceiling, or when an
    // edge arrives while already at the ceiling (both make acc_sum == MAX).
    ovf_now = ovf_acc_q | (spike_edge & (acc_sum == RATE_MAX));

    tmr_inc = (tmr_q == ISI_MAX) ? ISI_MAX : tmr_q + 1'b1;
  end

  always_comb begin
    spike_d      = spike;
    win_d        = win_q;
    acc_d        = acc_q;
    ovf_acc_d    = ovf_acc_q;
    tmr_d        = tmr_q;
    state_d      = state_q;
    rate_d       = rate_q;
    rate_valid_d = 1'b0;
    rate_ovf_d   = rate_ovf_q;
    isi_d        = isi_q;
    isi_valid_d  = 1'b0;

    if (en) begin
      win_d = win_last ? '0 : win_q + 1'b1;

      // Window close: an edge in the last cycle still belongs to the
      // closing window, so the loaded value already includes it.
      if (win_last) begin
        rate_d       = acc_sum;
        rate_ovf_d   = ovf_now;
        rate_valid_d = 1'b1;
        acc_d        = '0;
        ovf_acc_d    = 1'b0;
      end else begin
        acc_d     = acc_sum;
        ovf_acc_d = ovf_now;
      end

      case (state_q)
        ST_IDLE: begin
          if (spike_edge) begin
            tmr_d   = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // tmr counts cycles since the previous edge minus one, so tmr+1
          // is the edge-to-edge distance in cycles.
          if (spike_edge) begin
            isi_d       = tmr_inc;
            isi_valid_d = 1'b1;
            tmr_d       = '0;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      spike_q      <= 1'b0;
      win_q        <= '0;
      acc_q        <= '0;
      ovf_acc_q    <= 1'b0;
      tmr_q        <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      rate_ovf_q   <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      spike_q      <= spike_d;
      win_q        <= win_d;
      acc_q        <= acc_d;
      ovf_acc_q    <= ovf_acc_d;
      tmr_q        <= tmr_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      rate_ovf_q   <= rate_ovf_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
    end
  end

  assign rate       = rate_q;
  assign rate_valid = rate_valid_q;
  assign rate_ovf   = rate_ovf_q;
  assign isi        = isi_q;
  assign isi_valid  = isi_valid_q;

endmodule

// File: doc/lif_spike_decoder.md
# lif_spike_decoder

Receive-side counterpart of the LIF neuron. It turns the neuron's spike train back into numbers: spikes per fixed window (rate) and cycles between successive spikes (inter-spike interval, ISI). It sits between the neuron's `spike` output and the design's output pins or readout logic, and gives the bench and host a registered, handshake-free numeric view of firing activity.

## Interface
Parameters:
- `WINDOW`, default 1000: length of the rate window in enabled clock cycles; legal range is 2 to 2^24-1.
- `RATE_W`, default 8: width of the rate count.
- `ISI_W`, default 16: width of the ISI count.

Ports:
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `en`, input, 1: measurement enable; low freezes all counters.
- `spike`, input, 1: spike from the neuron; a level, where each 0→1 transition is one spike.
- `rate`, output, RATE_W: spike count of the last completed window, saturating.
- `rate_valid`, output, 1: one-cycle pulse when `rate` updates.
- `rate_ovf`, output, 1: set if the last completed window saturated; updates with `rate`.
- `isi`, output, ISI_W: cycles between the last two spikes, saturating.
- `isi_valid`, output, 1: one-cycle pulse when `isi` updates.

## Operation
- Edge detect:
  - `spike_q` is `spike` registered every cycle, regardless of `en`.
  - `edge = spike & ~spike_q & en`.
  - A level held high counts once.
- Window counter `win`:
  - Runs 0..WINDOW-1 while `en`=1 and wraps to 0.
  - Holds its value while `en`=0.
- Spike accumulator `acc`:
  - Adds 1 on `edge` and saturates at 2^RATE_W-1.
  - Reaching saturation, or an edge arriving while saturated, sets the sticky flag `ovf_acc`.
- Window close (`en`=1 and `win`==WINDOW-1):
  - `rate` is loaded with `acc` plus the edge in this same cycle, saturated.
  - `rate_ovf` is loaded with `ovf_acc`, including any saturation in this cycle.
  - `rate_valid` pulses.
  - `acc` and `ovf_acc` clear to 0.
- ISI state machine, two states:
  - `IDLE` (no spike seen yet): on `edge`, clear `tmr` and go to `RUN`; no `isi_valid`.
  - `RUN`:
    - `tmr` increments each enabled cycle and saturates at 2^ISI_W-1.
    - On `edge`, `isi` is loaded with `tmr+1`, saturated; `isi_valid` pulses; `tmr` clears.
    - The ISI value is therefore the number of clock cycles from one rising edge to the next.
- `en`=0: `win`, `acc` and `tmr` hold, no pulses are generated, and output registers hold their values.
- Reset:
  - `win`, `acc`, `ovf_acc`, `tmr` and `spike_q` go to 0, and the ISI machine goes to `IDLE`.
  - Outputs: `rate`=0, `rate_valid`=0, `rate_ovf`=0, `isi`=0, `isi_valid`=0.
  - Reset mid-window discards the partial count; no `rate_valid` is emitted for it.
- Reset has priority over `en` and over `edge`.

## Timing
- Every output is a register; there is no combinational path from inputs to outputs.
- Window latency: `rate`/`rate_valid` are visible on the clock edge following the `win`==WINDOW-1 cycle.
  - With `en` held high, `rate_valid` recurs exactly every WINDOW cycles.
  - The first `rate_valid` after reset deasserts comes WINDOW cycles later.
- Spike latency: `isi`/`isi_valid` are visible one cycle after the cycle in which `spike` first reads 1.
- Boundaries:
  - An edge in the last window cycle (`win`==WINDOW-1) counts in the closing window.
  - An edge at `win`==0 counts in the new window.
- Simultaneous window close and ISI update: both pulses occur in the same cycle, independently.
- Back-to-back spikes (0,1,0,1) give `isi`=2, the minimum possible value.
- `rate` takes values 0..min(2^RATE_W-1, WINDOW/2), since an edge needs at least 2 cycles per spike.

## Test plan
- WINDOW=10. Reset, then `en`=1 with `spike` low throughout → `rate_valid` pulses at cycles 10, 20, …, with `rate`=0 and `rate_ovf`=0; `isi_valid` never pulses.
- WINDOW=10, `spike` toggling 1,0 every cycle → `rate`=5 on each window; `isi`=2 with `isi_valid` pulsing every 2nd cycle after the second spike.
- WINDOW=1000, RATE_W=8, spike period 2 (500 spikes) → `rate`=255, `rate_ovf`=1; the next window, run with no spikes, reports `rate`=0 and `rate_ovf`=0.
- Spike rising edges at cycles 3 and 40, with `spike` held high 5 cycles each → exactly one count per pulse; `isi`=37 one cycle after the second edge.
- ISI_W=4, edges 30 cycles apart → `isi`=15 (saturated). Then hold `en`=0 for 7 cycles between two edges spaced 12 enabled cycles → `isi`=12 and no pulses while `en`=0.
- WINDOW=10: 3 spikes, then assert `rst` at `win`=6 → all outputs 0 the next cycle, no `rate_valid` for the partial window, and the next `rate_valid` comes 10 cycles after `rst` deasserts.
